ux607_subsys_irq_sched: RTL and testbench

- Interrupt conditioning and scheduling stage placed between the peripheral IRQ lines (GPIO, UART, QSPI, PWM, I2C) and the core-side interrupt consumer.
- Synchronises each raw line and applies per-line edge or level capture into pending bits.
- Tracks an in-service state per line and round-robin schedules one eligible IRQ at a time over a valid/ready claim handshake, completed by an end-of-interrupt (EOI) pulse.

---
 rtl/ux607_irq_pkg.sv | 23 ++
 rtl/ux607_subsys_irq_rr_arb.sv | 31 +++
 rtl/ux607_subsys_irq_sched.sv | 121 ++++++++++++
 tb/tb_ux607_subsys_irq_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ux607_irq_pkg.sv
// Shared types and constants for the ux607 interrupt scheduling slice.
// Also holds the ID-width helper used by the scheduler at elaboration.
package ux607_irq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_t;

    localparam int IRQ_NUM_DEF = 50;
    localparam int ID_W_DEF    = 6;

    // Smallest w with 2**w >= n.
    function automatic int id_bits(input int n);
        int r;
        r = 31;
        for (int w = 30; w >= 0; w--) begin
            if ((1 << w) >= n) r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/ux607_subsys_irq_rr_arb.sv
// Combinational round-robin picker: first set elig bit at or above ptr,
// wrapping N-1 -> 0.
module ux607_subsys_irq_rr_arb #(
    parameter int N = 50,
    parameter int W = 6
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] win_id_o
);

    logic [N-1:0] w_rot;

    // Rotate so that bit 0 is the line at ptr.
    assign w_rot = N'({elig_i, elig_i} >> ptr_i);

    always_comb begin
        any_o    = 1'b0;
        win_id_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                any_o    = 1'b1;
                win_id_o = (int'(ptr_i) + k >= N) ?
                           W'(int'(ptr_i) + k - N) :
                           W'(int'(ptr_i) + k);
            end
        end
    end

endmodule

// File: rtl/ux607_subsys_irq_sched.sv
// Peripheral IRQ conditioning and round-robin scheduler with a
// valid/ready claim handshake and EOI-driven in-service tracking.
module ux607_subsys_irq_sched
    import ux607_irq_pkg::*;
#(
    parameter int IRQ_NUM     = IRQ_NUM_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_NUM-1:0] irq_src_i,
    input  logic [IRQ_NUM-1:0] cfg_en_i,
    input  logic [IRQ_NUM-1:0] cfg_edge_i,
    input  logic [IRQ_NUM-1:0] sw_clr_i,
    output logic               req_valid_o,
    output logic [ID_W-1:0]    req_id_o,
    input  logic               req_ready_i,
    input  logic               eoi_valid_i,
    input  logic [ID_W-1:0]    eoi_id_i,
    output logic [IRQ_NUM-1:0] pend_o,
    output logic [IRQ_NUM-1:0] insvc_o
);

    if (id_bits(IRQ_NUM) > ID_W) begin : g_bad_id_w
        $error("ID_W too narrow for IRQ_NUM");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0][IRQ_NUM-1:0] r_sync;
    logic [IRQ_NUM-1:0] r_prev;
    logic [IRQ_NUM-1:0] r_pend;
    logic [IRQ_NUM-1:0] r_insvc;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic               r_valid;
    irq_state_t         r_state;

    logic [IRQ_NUM-1:0] w_s;
    logic [IRQ_NUM-1:0] w_rise;
    logic [IRQ_NUM-1:0] w_elig;
    logic [IRQ_NUM-1:0] w_claim;
    logic [IRQ_NUM-1:0] w_eoi;
    logic [IRQ_NUM-1:0] w_pend_nxt;
    logic               w_hs;
    logic               w_any;
    logic [ID_W-1:0]    w_win;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    assign w_elig = r_pend & cfg_en_i & ~r_insvc;
    assign w_hs   = r_valid & req_ready_i;

    // Out-of-range EOI IDs decode to no bit and are dropped.
    always_comb begin
        w_claim = '0;
        w_eoi   = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            w_claim[i] = w_hs && (r_id == ID_W'(i));
            w_eoi[i]   = eoi_valid_i && (eoi_id_i == ID_W'(i));
        end
    end

    // Edge set beats clear; level lines just follow the synchroniser.
    assign w_pend_nxt =
        (cfg_edge_i & (w_rise | (r_pend & ~(sw_clr_i | w_claim)))) |
        (~cfg_edge_i & w_s);

    ux607_subsys_irq_rr_arb #(
        .N (IRQ_NUM),
        .W (ID_W)
    ) u_arb (
        .elig_i   (w_elig),
        .ptr_i    (r_ptr),
        .any_o    (w_any),
        .win_id_o (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_insvc <= '0;
            r_ptr   <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], irq_src_i};
            r_prev  <= w_s;
            r_pend  <= w_pend_nxt;
            r_insvc <= (r_insvc & ~w_eoi) | w_claim;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (req_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                        r_ptr   <= (r_id == ID_W'(IRQ_NUM - 1)) ?
                                   '0 : r_id + 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_valid_o = r_valid;
    assign req_id_o    = r_id;
    assign pend_o      = r_pend;
    assign insvc_o     = r_insvc;

endmodule

// File: tb/tb_ux607_subsys_irq_sched.sv
// Self-checking bench for ux607_subsys_irq_sched: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_ux607_subsys_irq_sched;

    localparam int N = 50;
    localparam int W = 6;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src = '0;
    logic [N-1:0] en = '0;
    logic [N-1:0] edg = '0;
    logic [N-1:0] clr = '0;
    logic         ready = 1'b0;
    logic         eoi_v = 1'b0;
    logic [W-1:0] eoi_id = '0;
    logic         req_valid_o;
    logic [W-1:0] req_id_o;
    logic [N-1:0] pend_o;
    logic [N-1:0] insvc_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int claims[$];
    int ccyc[$];

    ux607_subsys_irq_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src_i   (src),
        .cfg_en_i    (en),
        .cfg_edge_i  (edg),
        .sw_clr_i    (clr),
        .req_valid_o (req_valid_o),
        .req_id_o    (req_id_o),
        .req_ready_i (ready),
        .eoi_valid_i (eoi_v),
        .eoi_id_i    (eoi_id),
        .pend_o      (pend_o),
        .insvc_o     (insvc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)",
                         nm, act, exp, $time);
        end
    endtask

    // Behavioural model: spec rules applied once per clock.
    logic [N-1:0] h [0:3] = '{default: '0};
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_insvc = '0;
    logic [N-1:0] m_np;
    logic [N-1:0] m_elig;
    logic [N-1:0] m_s;
    logic [N-1:0] m_p;
    int           m_ptr = 0;
    int           m_id = 0;
    bit           m_valid = 0;
    bit           m_hs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) h[i] = '0;
            m_pend = '0;
            m_insvc = '0;
            m_ptr = 0;
            m_id = 0;
            m_valid = 0;
        end else begin
            m_s = h[S-1];
            m_p = h[S];
            m_elig = m_pend & en & ~m_insvc;
            m_hs = m_valid && ready;
            for (int i = 0; i < N; i++) begin
                if (edg[i])
                    m_np[i] = (m_s[i] && !m_p[i]) ||
                              (m_pend[i] && !clr[i] && !(m_hs && m_id == i));
                else
                    m_np[i] = m_s[i];
            end
            if (eoi_v && int'(eoi_id) < N) m_insvc[eoi_id] = 1'b0;
            if (m_hs) m_insvc[m_id] = 1'b1;
            if (m_valid) begin
                if (m_hs) begin
                    m_valid = 0;
                    m_ptr = (m_id + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_valid && m_elig[(m_ptr + k) % N]) begin
                        m_valid = 1;
                        m_id = (m_ptr + k) % N;
                    end
                end
            end
            m_pend = m_np;
            for (int i = 3; i > 0; i--) h[i] = h[i-1];
            h[0] = src;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && req_valid_o && ready) begin
            claims.push_back(int'(req_id_o));
            ccyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 64'(req_valid_o), 64'(m_valid));
            if (m_valid) chk("id", 64'(req_id_o), 64'(m_id));
            chk("pend", 64'(pend_o), 64'(m_pend));
            chk("insvc", 64'(insvc_o), 64'(m_insvc));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        src = '0; clr = '0; ready = 1'b0; eoi_v = 1'b0;
        en = '1; edg = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        claims.delete();
        ccyc.delete();
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int c;
        c = 0;
        while (!req_valid_o && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (!req_valid_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout got valid=0 expected valid=1", nm);
        end
    endtask

    task automatic pulse_eoi(input int id);
        eoi_v = 1'b1;
        eoi_id = W'(id);
        @(negedge clk);
        eoi_v = 1'b0;
    endtask

    initial begin
        bit held;
        #1;
        @(negedge clk);
        chk("rst_valid", 64'(req_valid_o), 64'd0);
        chk("rst_pend", 64'(pend_o), 64'd0);
        do_reset();

        // Single edge pulse on line 5
        src[5] = 1'b1;
        @(negedge clk); src[5] = 1'b0;
        @(negedge clk); chk("t1_pend_k1", 64'(pend_o[5]), 64'd0);
        @(negedge clk);
        chk("t1_pend_k2", 64'(pend_o[5]), 64'd1);
        chk("t1_mdl_pend", 64'(m_pend[5]), 64'd1);
        chk("t1_valid_k2", 64'(req_valid_o), 64'd0);
        @(negedge clk);
        chk("t1_valid_k3", 64'(req_valid_o), 64'd1);
        chk("t1_id_k3", 64'(req_id_o), 64'd5);
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        chk("t1_pend_hs", 64'(pend_o[5]), 64'd0);
        chk("t1_insvc_hs", 64'(insvc_o[5]), 64'd1);
        chk("t1_valid_hs", 64'(req_valid_o), 64'd0);

        // Lines 3, 7, 40 served in order with 2-cycle spacing
        do_reset();
        src[3] = 1'b1; src[7] = 1'b1; src[40] = 1'b1;
        @(negedge clk); src = '0; ready = 1'b1;
        repeat (12) @(negedge clk);
        ready = 1'b0;
        chk("t2_nclaims", 64'(claims.size()), 64'd3);
        if (claims.size() == 3) begin
            chk("t2_c0", 64'(claims[0]), 64'd3);
            chk("t2_c1", 64'(claims[1]), 64'd7);
            chk("t2_c2", 64'(claims[2]), 64'd40);
            chk("t2_gap1", 64'(ccyc[1] - ccyc[0]), 64'd2);
            chk("t2_gap2", 64'(ccyc[2] - ccyc[1]), 64'd2);
        end
        chk("t2_idle", 64'(req_valid_o), 64'd0);

        // Level line 10 gated by in-service until EOI
        do_reset();
        edg[10] = 1'b0;
        src[10] = 1'b1;
        wait_valid(10, "t3_first");
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_one_claim", 64'(claims.size()), 64'd1);
        chk("t3_blocked", 64'(req_valid_o), 64'd0);
        pulse_eoi(10);
        chk("t3_bubble", 64'(req_valid_o), 64'd0);
        @(negedge clk);
        chk("t3_reoffer", 64'(req_valid_o), 64'd1);
        chk("t3_reoffer_id", 64'(req_id_o), 64'd10);
        src[10] = 1'b0; ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        repeat (4) @(negedge clk);
        pulse_eoi(10);
        repeat (6) @(negedge clk);
        chk("t3_no_more", 64'(req_valid_o), 64'd0);
        chk("t3_nclaims", 64'(claims.size()), 64'd2);

        // Offer on 12 is held despite enable drop and a new line 2
        do_reset();
        src[12] = 1'b1;
        @(negedge clk); src[12] = 1'b0;
        wait_valid(10, "t4_first");
        chk("t4_id12", 64'(req_id_o), 64'd12);
        en[12] = 1'b0; src[2] = 1'b1;
        held = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            src[2] = 1'b0;
            if (!(req_valid_o && req_id_o == W'(12))) held = 0;
        end
        chk("t4_held", 64'(held), 64'd1);
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        wait_valid(10, "t4_next");
        chk("t4_id2", 64'(req_id_o), 64'd2);
        ready = 1'b1;
        @(negedge clk); ready = 1'b0;

        // Claim/EOI collision, bad EOI id, clear vs set
        do_reset();
        src[9] = 1'b1;
        @(negedge clk); src[9] = 1'b0;
        wait_valid(10, "t5_first");
        chk("t5_id9", 64'(req_id_o), 64'd9);
        ready = 1'b1; eoi_v = 1'b1; eoi_id = 6'd9;
        @(negedge clk); ready = 1'b0; eoi_v = 1'b0;
        chk("t5_claim_wins", 64'(insvc_o[9]), 64'd1);
        pulse_eoi(55);
        chk("t5_eoi55_insvc", 64'(insvc_o), 64'(50'd1 << 9));
        chk("t5_eoi55_pend", 64'(pend_o), 64'd0);
        en[4] = 1'b0; src[4] = 1'b1;
        @(negedge clk);
        @(negedge clk); clr[4] = 1'b1;
        @(negedge clk); clr[4] = 1'b0;
        chk("t5_set_wins", 64'(pend_o[4]), 64'd1);
        clr[4] = 1'b1;
        @(negedge clk); clr[4] = 1'b0;
        chk("t5_clr", 64'(pend_o[4]), 64'd0);

        // Reset during an offer with source held high
        do_reset();
        src[20] = 1'b1;
        wait_valid(10, "t6_first");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(req_valid_o), 64'd0);
        chk("t6_async_pend", 64'(pend_o), 64'd0);
        chk("t6_async_insvc", 64'(insvc_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        claims.delete();
        ready = 1'b1;
        repeat (12) @(negedge clk);
        ready = 1'b0;
        chk("t6_nclaims", 64'(claims.size()), 64'd1);
        if (claims.size() == 1) chk("t6_id", 64'(claims[0]), 64'd20);
        chk("t6_pend", 64'(pend_o[20]), 64'd0);

        // Randomized traffic
        do_reset();
        edg = {$urandom, $urandom};
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) src[i] = ~src[i];
            clr = '0;
            if ($urandom_range(0, 3) == 0) clr[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) edg[$urandom_range(0, N - 1)] ^= 1'b1;
            ready = ($urandom_range(0, 2) != 0);
            eoi_v = ($urandom_range(0, 2) == 0);
            eoi_id = ($urandom_range(0, 7) == 0) ? W'($urandom_range(50, 63)) :
                                                   W'($urandom_range(0, N - 1));
        end
        @(negedge clk);
        eoi_v = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
